alu_mul_sequencer: RTL and testbench

- Multi-cycle initiator that drives the 8-bit combinational ALU through its op/operand interface. It sequences ALU ADD and SHIFT_RIGHT primitives to compute an unsigned 8x8 -> 16-bit product.
- Sits between the processor's execute stage (valid/ready request and response) and a dedicated ALU instance. It owns the ALU's control inputs and consumes the ALU's Out and CarryOut.
- Latency is fixed regardless of operand values.

---
 rtl/alu_mul_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 8x8 unsigned multiplier that sequences an external 8-bit ALU.
// One ADD/SHIFT pair per multiplier bit; fixed latency regardless of operands.
module alu_mul_sequencer #(
    parameter logic [3:0] OP_PASS_A      = 4'd0,
    parameter logic [3:0] OP_SHIFT_RIGHT = 4'd2,
    parameter logic [3:0] OP_ADD         = 4'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_product,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAdd   = 2'd1;
    localparam logic [1:0] StShift = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  md_q, md_d;
    logic [7:0]  ph_q, ph_d;
    logic [7:0]  ml_q, ml_d;
    logic        cs_q, cs_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_product_q, rsp_product_d;

    always_comb begin
        state_d       = state_q;
        md_d          = md_q;
        ph_d          = ph_q;
        ml_d          = ml_q;
        cs_d          = cs_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_product_d = rsp_product_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    md_d    = req_a;
                    ml_d    = req_b;
                    ph_d    = 8'd0;
                    cs_d    = 1'b0;
                    cnt_d   = 3'd0;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                // PASS_A leaves CarryOut undefined, so only a real add may set cs.
                if (ml_q[0]) begin
                    ph_d = alu_out;
                    cs_d = alu_carry;
                end else begin
                    cs_d = 1'b0;
                end
                state_d = StShift;
            end
            StShift: begin
                ph_d  = {cs_q, alu_out[6:0]};
                ml_d  = {alu_carry, ml_q[7:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d       = StDone;
                    rsp_valid_d   = 1'b1;
                    rsp_product_d = {cs_q, alu_out[6:0], alu_carry, ml_q[7:1]};
                end else begin
                    state_d = StAdd;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            md_q          <= 8'd0;
            ph_q          <= 8'd0;
            ml_q          <= 8'd0;
            cs_q          <= 1'b0;
            cnt_q         <= 3'd0;
            rsp_valid_q   <= 1'b0;
            rsp_product_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            md_q          <= md_d;
            ph_q          <= ph_d;
            ml_q          <= ml_d;
            cs_q          <= cs_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_product_q <= rsp_product_d;
        end
    end

    // ALU controls depend only on state and registers, never on req_*.
    always_comb begin
        alu_op = OP_PASS_A;
        alu_a  = 8'd0;
        alu_b  = 8'd0;
        unique case (state_q)
            StAdd: begin
                alu_op = ml_q[0] ? OP_ADD : OP_PASS_A;
                alu_a  = ph_q;
                alu_b  = md_q;
            end
            StShift: begin
                alu_op = OP_SHIFT_RIGHT;
                alu_a  = ph_q;
            end
            default: ;
        endcase
    end

    assign req_ready   = (state_q == StIdle);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = rsp_product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU, arithmetic reference model with
// per-cycle compare, plus directed operations with hand-computed products.
module tb_alu_mul_sequencer;

    localparam logic [3:0] OpPass  = 4'd0;
    localparam logic [3:0] OpShift = 4'd2;
    localparam logic [3:0] OpAdd   = 4'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_product;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_out;
    logic        alu_carry;

    int n_checks = 0;
    int n_fail   = 0;
    int n_hs     = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    alu_mul_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .alu_carry   (alu_carry)
    );

    // Behavioural ALU; PASS_A drives a junk carry of 1 to expose misuse.
    always_comb begin
        alu_out   = 8'd0;
        alu_carry = 1'b0;
        case (alu_op)
            OpPass: begin
                alu_out   = alu_a;
                alu_carry = 1'b1;
            end
            OpShift: begin
                alu_out   = {1'b0, alu_a[7:1]};
                alu_carry = alu_a[0];
            end
            OpAdd: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: busy for 16 cycles after accept, then holds a*b until consumed.
    logic        m_busy;
    int unsigned m_age;
    logic [7:0]  m_a, m_b;
    logic        m_rv;
    logic [15:0] m_rp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            m_rv   <= 1'b0;
            m_rp   <= 16'd0;
        end else if (!m_busy && !m_rv) begin
            if (req_valid) begin
                m_busy <= 1'b1;
                m_age  <= 0;
                m_a    <= req_a;
                m_b    <= req_b;
            end
        end else if (m_busy) begin
            if (m_age == 15) begin
                m_busy <= 1'b0;
                m_rv   <= 1'b1;
                m_rp   <= {8'd0, m_a} * {8'd0, m_b};
            end else begin
                m_age <= m_age + 1;
            end
        end else if (rsp_ready) begin
            m_rv <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!reset && rsp_valid && rsp_ready) n_hs <= n_hs + 1;
    end

    // After i iterations the high byte of the partial product is (a * (b mod 2^i)) >> i.
    always @(negedge clk) begin
        int unsigned it, pa;
        logic [3:0]  eop;
        logic [7:0]  ea, eb;
        if (cmp_en) begin
            check("req_ready", {31'd0, req_ready}, {31'd0, !m_busy && !m_rv});
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
            check("rsp_product", {16'd0, rsp_product}, {16'd0, m_rp});
            eop = OpPass;
            ea  = 8'd0;
            eb  = 8'd0;
            if (m_busy) begin
                it = m_age / 2;
                if (m_age % 2 == 0) begin
                    eop = m_b[it] ? OpAdd : OpPass;
                    pa  = (m_a * (m_b & ((1 << it) - 1))) >> it;
                    ea  = pa[7:0];
                    eb  = m_a;
                end else begin
                    eop = OpShift;
                    pa  = (m_a * (m_b & ((1 << (it + 1)) - 1))) >> it;
                    ea  = pa[7:0];
                end
            end
            check("alu_op", {28'd0, alu_op}, {28'd0, eop});
            check("alu_a", {24'd0, alu_a}, {24'd0, ea});
            check("alu_b", {24'd0, alu_b}, {24'd0, eb});
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check("ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    // Issue one multiply; stall = cycles rsp_ready is held low, jam = busy-time req spam.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                           input int stall, input bit jam);
        int lat;
        @(posedge clk);
        #2;
        wait_ready();
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        rsp_ready = (stall == 0);
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            if (jam) begin
                req_valid = 1'b1;
                req_a     = 8'($urandom);
                req_b     = 8'($urandom);
            end
            @(posedge clk);
            #2;
            lat++;
        end
        req_valid = 1'b0;
        // 16 edges after the accept edge, i.e. the 17th cycle counting the accept cycle.
        check("latency", lat, 32'd16);
        check("product", {16'd0, rsp_product}, {16'd0, exp});
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_product", {16'd0, rsp_product}, {16'd0, exp});
            @(posedge clk);
            #2;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        check("post_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_ready", {31'd0, req_ready}, 32'd1);
        check("post_product", {16'd0, rsp_product}, {16'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_a     = 8'd0;
        req_b     = 8'd0;
        rsp_ready = 1'b1;
        #12;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_product", {16'd0, rsp_product}, 32'd0);
        check("rst_alu_op", {28'd0, alu_op}, 32'd0);
        @(posedge clk);
        #2;
        reset  = 1'b0;
        cmp_en = 1'b1;

        run_mul(8'd13, 8'd11, 16'h008F, 0, 1'b0);
        run_mul(8'd255, 8'd255, 16'hFE01, 0, 1'b0);
        run_mul(8'd0, 8'd200, 16'h0000, 0, 1'b0);
        run_mul(8'd200, 8'd0, 16'h0000, 0, 1'b0);
        run_mul(8'd7, 8'd9, 16'h003F, 5, 1'b0);
        run_mul(8'd2, 8'd3, 16'h0006, 0, 1'b0);

        // Abort 100*100 with a mid-cycle reset.
        @(posedge clk);
        #2;
        wait_ready();
        req_valid = 1'b1;
        req_a     = 8'd100;
        req_b     = 8'd100;
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_rsp_product", {16'd0, rsp_product}, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        run_mul(8'd100, 8'd100, 16'h2710, 0, 1'b0);
        run_mul(8'd37, 8'd201, 16'h1D0D, 0, 1'b1);

        repeat (3) @(posedge clk);
        #2;
        check("response_count", n_hs, 32'd8);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
